comparator_arbiter: RTL

//  - Shares one external WIDTH-bit magnitude comparator among NREQ requesters.
//  - Round-robin arbitration with a valid/ready handshake per requester.
//  - Drives the comparator operands from registers and captures its Greater/Equal/Less flags.
//  - Returns a tagged response through a single valid/ready response port.

---
 rtl/comparator_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/comparator_arbiter.sv
// Round-robin arbiter sharing one external magnitude comparator among NREQ requesters.
// Optional flag sanity checking (sticky o_err) is built when CMP_ARB_CHECK_EN is defined.
module comparator_arbiter #(
    parameter  int WIDTH = 4,
    parameter  int NREQ  = 4,
    localparam int ID_W  = $clog2(NREQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*WIDTH-1:0] i_req_a,
    input  logic [NREQ*WIDTH-1:0] i_req_b,
    output logic [NREQ-1:0]       o_req_ready,
    output logic [WIDTH-1:0]      o_cmp_a,
    output logic [WIDTH-1:0]      o_cmp_b,
    input  logic                  i_cmp_greater,
    input  logic                  i_cmp_equal,
    input  logic                  i_cmp_less,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [ID_W-1:0]       o_rsp_id,
    output logic                  o_rsp_greater,
    output logic                  o_rsp_equal,
    output logic                  o_rsp_less,
    output logic                  o_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ID_W-1:0]   r_last_grant;
    logic [WIDTH-1:0]  r_cmp_a;
    logic [WIDTH-1:0]  r_cmp_b;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic              r_rsp_greater;
    logic              r_rsp_equal;
    logic              r_rsp_less;

    logic [NREQ-1:0]   w_grant;
    logic              w_found;
    logic              w_xfer;
    logic [ID_W-1:0]   w_win_id;
    logic [WIDTH-1:0]  w_sel_a;
    logic [WIDTH-1:0]  w_sel_b;
    int                w_dist;
    int                w_best_d;
    int                w_best;

    // Round-robin pick: the valid requester closest after r_last_grant wins.
    always_comb begin
        w_found  = 1'b0;
        w_grant  = {NREQ{1'b0}};
        w_sel_a  = {WIDTH{1'b0}};
        w_sel_b  = {WIDTH{1'b0}};
        w_dist   = 0;
        w_best_d = NREQ;
        w_best   = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + NREQ - 1 - int'(r_last_grant)) % NREQ;
            if (i_req_valid[i] && (w_dist < w_best_d)) begin
                w_best_d = w_dist;
                w_best   = i;
                w_found  = 1'b1;
            end else begin
                w_found  = w_found;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_found && (w_best == i)) begin
                w_grant[i] = 1'b1;
                w_sel_a    = i_req_a[i*WIDTH +: WIDTH];
                w_sel_b    = i_req_b[i*WIDTH +: WIDTH];
            end else begin
                w_grant[i] = 1'b0;
            end
        end
        w_win_id = ID_W'(w_best);
    end

    assign o_req_ready = (r_state == S_IDLE) ? w_grant : {NREQ{1'b0}};
    assign w_xfer      = (r_state == S_IDLE) && w_found;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; no bypass from RESP straight into a new grant.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = w_xfer ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next_state = S_RESP;
            S_RESP:  w_next_state = i_rsp_ready ? S_IDLE : S_RESP;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, capture flags in ISSUE, hold until consumed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant  <= ID_W'(NREQ - 1);
            r_cmp_a       <= {WIDTH{1'b0}};
            r_cmp_b       <= {WIDTH{1'b0}};
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= {ID_W{1'b0}};
            r_rsp_greater <= 1'b0;
            r_rsp_equal   <= 1'b0;
            r_rsp_less    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_cmp_a      <= w_sel_a;
                        r_cmp_b      <= w_sel_b;
                        r_last_grant <= w_win_id;
                        r_rsp_id     <= w_win_id;
                    end else begin
                        r_cmp_a      <= r_cmp_a;
                    end
                end
                S_ISSUE: begin
                    r_rsp_greater <= i_cmp_greater;
                    r_rsp_equal   <= i_cmp_equal;
                    r_rsp_less    <= i_cmp_less;
                    r_rsp_valid   <= 1'b1;
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end else begin
                        r_rsp_valid <= r_rsp_valid;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmp_a       = r_cmp_a;
    assign o_cmp_b       = r_cmp_b;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_id      = r_rsp_id;
    assign o_rsp_greater = r_rsp_greater;
    assign o_rsp_equal   = r_rsp_equal;
    assign o_rsp_less    = r_rsp_less;

`ifdef CMP_ARB_CHECK_EN
    function automatic logic f_flags_onehot(input logic [2:0] flags);
        return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    endfunction

    logic r_err;

    // Sticky error when the comparator presents an inconsistent flag set at capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if ((r_state == S_ISSUE) &&
                     !f_flags_onehot({i_cmp_greater, i_cmp_equal, i_cmp_less})) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule
